// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, entry layout and FSM state type for the fetch stage.
//   DEFAULT_RESET_PC : first fetch address after reset
//   INST_NOP         : canonical NOP word (addi x0,x0,0)
//   fetch_entry_t    : buffered entry {fault, pc, instr}, 65 bits
package fetch_pkg;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam int ENTRY_W         = 65;
    localparam int ENTRY_INSTR_LSB = 0;
    localparam int ENTRY_PC_LSB    = 32;
    localparam int ENTRY_FAULT_BIT = 64;
    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular instruction buffer with flush.
//   clk_i, rst_i (sync, active-low) ; flush_i empties the buffer
//   push_i/data_i write the tail ; pop_i advances the head
//   data_o head entry ; empty_o ; count_o occupancy
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr, r_wr_ptr;
    logic [AW:0]      r_count;
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop_i)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) r_mem[r_wr_ptr] <= data_i;
    end
    assign data_o  = r_mem[r_rd_ptr];
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC generation, I-cache request/response tracking,
// instruction buffering and redirect handling for the decode stage.
//   clk_i, rst_i (sync, active-low)
//   branch_request_i/branch_pc_i : redirect from execute/CSR
//   icache_rd_o/icache_pc_o/icache_accept_i : request channel
//   icache_valid_i/icache_error_i/icache_inst_i : response channel
//   fetch_valid_o/fetch_instr_o/fetch_pc_o/fetch_fault_o/fetch_accept_i : decode handshake
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,
    input  logic [31:0] branch_pc_i,
    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic        icache_error_i,
    input  logic [31:0] icache_inst_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_fault_o,
    input  logic        fetch_accept_i
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_t       r_state, w_state_nxt;
    logic [31:0]        r_pc, w_pc_nxt;
    logic               r_outstanding, w_outstanding_nxt;
    logic               r_drop, w_drop_nxt;
    logic [CW-1:0]      w_count;
    logic [ENTRY_W-1:0] w_head;
    fetch_entry_t       w_push_e;
    logic               w_empty, w_resp, w_push, w_pop, w_credit, w_rd, w_accept;
    logic               w_unused;
    assign w_unused = ^branch_pc_i[1:0];
    assign w_resp   = icache_valid_i && r_outstanding;
    assign w_push   = w_resp && !r_drop && !branch_request_i;
    assign w_pop    = fetch_valid_o && fetch_accept_i;
    // Reserve a slot for the in-flight response so the buffer can never overflow.
    assign w_credit = ({1'b0, w_count} + {{CW{1'b0}}, r_outstanding}) < (CW+1)'(FIFO_DEPTH);
    assign w_rd     = rst_i && (r_state == ST_RUN) && !r_drop && !branch_request_i
                      && (!r_outstanding || icache_valid_i) && w_credit;
    assign w_accept = w_rd && icache_accept_i;
    // pc_q has already advanced past the outstanding request when its response returns.
    assign w_push_e = '{fault: icache_error_i, pc: r_pc - 32'd4,
                        instr: icache_error_i ? 32'h0 : icache_inst_i};
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (branch_request_i),
        .push_i  (w_push),
        .data_i  (w_push_e),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .empty_o (w_empty),
        .count_o (w_count)
    );
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_outstanding <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_drop        <= w_drop_nxt;
        end
    end
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_outstanding_nxt = r_outstanding;
        w_drop_nxt        = r_drop;
        if (branch_request_i) begin
            w_state_nxt       = ST_RUN;
            w_pc_nxt          = {branch_pc_i[31:2], 2'b00};
            // A request still in flight after the redirect must have its response discarded.
            w_outstanding_nxt = r_outstanding && !icache_valid_i;
            w_drop_nxt        = r_outstanding && !icache_valid_i;
        end else begin
            if (w_push && icache_error_i) w_state_nxt = ST_HALT;
            if (w_accept) w_pc_nxt = r_pc + 32'd4;
            w_outstanding_nxt = w_accept || (r_outstanding && !icache_valid_i);
            if (w_resp) w_drop_nxt = 1'b0;
        end
    end
    assign icache_rd_o   = w_rd;
    assign icache_pc_o   = r_pc;
    assign fetch_valid_o = !w_empty;
    assign fetch_instr_o = w_empty ? 32'h0 : w_head[ENTRY_INSTR_LSB +: 32];
    assign fetch_pc_o    = w_empty ? 32'h0 : w_head[ENTRY_PC_LSB +: 32];
    assign fetch_fault_o = !w_empty && w_head[ENTRY_FAULT_BIT];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
module tb_fetch_unit;
    import fetch_pkg::*;
    logic        clk_i = 1'b0;
    logic        rst_i, branch_request_i, icache_accept_i, icache_valid_i, icache_error_i, fetch_accept_i;
    logic [31:0] branch_pc_i, icache_inst_i;
    logic        icache_rd_o, fetch_valid_o, fetch_fault_o;
    logic [31:0] icache_pc_o, fetch_instr_o, fetch_pc_o;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        auto_cache = 1'b0;
    logic [31:0] err_pc = 32'hFFFF_FFFF;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;
    ent_t got[$];

    always #5 clk_i = ~clk_i;

    fetch_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .branch_request_i (branch_request_i),
        .branch_pc_i      (branch_pc_i),
        .icache_rd_o      (icache_rd_o),
        .icache_pc_o      (icache_pc_o),
        .icache_accept_i  (icache_accept_i),
        .icache_valid_i   (icache_valid_i),
        .icache_error_i   (icache_error_i),
        .icache_inst_i    (icache_inst_i),
        .fetch_valid_o    (fetch_valid_o),
        .fetch_instr_o    (fetch_instr_o),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_fault_o    (fetch_fault_o),
        .fetch_accept_i   (fetch_accept_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: record decode pops and, in auto mode, act as a cache that
    // responds one cycle after accepting (error on err_pc, refusing the next request then).
    task automatic tick();
        logic        issued;
        logic [31:0] ipc;
        ent_t        e;
        @(negedge clk_i);
        issued = icache_rd_o && icache_accept_i;
        ipc    = icache_pc_o;
        if (fetch_valid_o && fetch_accept_i && rst_i && !branch_request_i) begin
            e.pc    = fetch_pc_o;
            e.instr = fetch_instr_o;
            e.fault = fetch_fault_o;
            got.push_back(e);
        end
        @(posedge clk_i);
        #1;
        if (auto_cache) begin
            icache_valid_i  = issued;
            icache_error_i  = issued && (ipc == err_pc);
            icache_inst_i   = (issued && ipc != err_pc) ? INST_NOP : 32'h0;
            icache_accept_i = !(issued && ipc == err_pc);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        auto_cache = 1'b0;
        branch_request_i = 1'b0;
        icache_accept_i = 1'b0;
        icache_valid_i = 1'b0;
        icache_error_i = 1'b0;
        fetch_accept_i = 1'b0;
        repeat (2) tick();
        got.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        branch_pc_i = 32'h0;
        icache_inst_i = 32'h0;
        do_reset();
        chkb("rst_rd", icache_rd_o, 1'b0);
        chk("rst_icache_pc", icache_pc_o, 32'h8000_0000);
        chkb("rst_valid", fetch_valid_o, 1'b0);
        chk("rst_instr", fetch_instr_o, 32'h0);
        chk("rst_fetch_pc", fetch_pc_o, 32'h0);
        chkb("rst_fault", fetch_fault_o, 1'b0);

        // Streaming with an immediately responding cache
        rst_i = 1'b1; fetch_accept_i = 1'b1; icache_accept_i = 1'b1; auto_cache = 1'b1;
        #1;
        chkb("t1_rd_first", icache_rd_o, 1'b1);
        chk("t1_pc_first", icache_pc_o, 32'h8000_0000);
        tick();
        chkb("t1_rd_second", icache_rd_o, 1'b1);
        chk("t1_pc_second", icache_pc_o, 32'h8000_0004);
        tick();
        chkb("t1_valid", fetch_valid_o, 1'b1);
        chk("t1_out_pc", fetch_pc_o, 32'h8000_0000);
        chk("t1_out_instr", fetch_instr_o, INST_NOP);
        chkb("t1_out_fault", fetch_fault_o, 1'b0);
        repeat (10) tick();
        chkb("t1_count", got.size() >= 5, 1'b1);
        for (int i = 0; i < got.size(); i++) begin
            chk("t1_seq_pc", got[i].pc, 32'h8000_0000 + 32'(4 * i));
            chk("t1_seq_instr", got[i].instr, INST_NOP);
        end

        // Backpressure from decode
        do_reset();
        rst_i = 1'b1; fetch_accept_i = 1'b0; icache_accept_i = 1'b1; auto_cache = 1'b1;
        repeat (10) tick();
        chkb("t2_rd_full", icache_rd_o, 1'b0);
        chkb("t2_valid", fetch_valid_o, 1'b1);
        chk("t2_head", fetch_pc_o, 32'h8000_0000);
        fetch_accept_i = 1'b1;
        #1;
        tick();
        chkb("t2_valid2", fetch_valid_o, 1'b1);
        chk("t2_second", fetch_pc_o, 32'h8000_0004);
        chkb("t2_rd_resume", icache_rd_o, 1'b1);
        chk("t2_pc_resume", icache_pc_o, 32'h8000_0008);
        tick();
        chkb("t2_drained", fetch_valid_o, 1'b0);
        repeat (6) tick();
        chkb("t2_count", got.size() >= 4, 1'b1);
        for (int i = 0; i < got.size(); i++)
            chk("t2_seq_pc", got[i].pc, 32'h8000_0000 + 32'(4 * i));

        // Redirect while a request is outstanding
        do_reset();
        rst_i = 1'b1; fetch_accept_i = 1'b1; icache_accept_i = 1'b1;
        #1;
        tick();
        icache_accept_i = 1'b0; branch_request_i = 1'b1; branch_pc_i = 32'h8000_0102;
        #1;
        chkb("t3_rd_branch", icache_rd_o, 1'b0);
        tick();
        branch_request_i = 1'b0;
        #1;
        chkb("t3_flush", fetch_valid_o, 1'b0);
        chkb("t3_rd_drop1", icache_rd_o, 1'b0);
        chk("t3_new_pc", icache_pc_o, 32'h8000_0100);
        tick();
        chkb("t3_rd_drop2", icache_rd_o, 1'b0);
        tick();
        icache_valid_i = 1'b1; icache_inst_i = 32'hDEAD_BEEF; icache_accept_i = 1'b1;
        #1;
        chkb("t3_rd_drop3", icache_rd_o, 1'b0);
        tick();
        icache_valid_i = 1'b0;
        #1;
        chkb("t3_stale_dropped", fetch_valid_o, 1'b0);
        chkb("t3_rd_new", icache_rd_o, 1'b1);
        chk("t3_req_pc", icache_pc_o, 32'h8000_0100);
        auto_cache = 1'b1;
        tick();
        tick();
        chkb("t3_valid", fetch_valid_o, 1'b1);
        chk("t3_out_pc", fetch_pc_o, 32'h8000_0100);
        chk("t3_out_instr", fetch_instr_o, INST_NOP);

        // Fetch fault halts fetching until a redirect
        do_reset();
        rst_i = 1'b1; fetch_accept_i = 1'b1; icache_accept_i = 1'b1; auto_cache = 1'b1;
        err_pc = 32'h8000_0008;
        repeat (5) tick();
        chkb("t4_valid", fetch_valid_o, 1'b1);
        chk("t4_pc", fetch_pc_o, 32'h8000_0008);
        chkb("t4_fault", fetch_fault_o, 1'b1);
        chk("t4_instr", fetch_instr_o, 32'h0);
        chkb("t4_rd_halt", icache_rd_o, 1'b0);
        repeat (3) tick();
        chkb("t4_rd_still_halt", icache_rd_o, 1'b0);
        chkb("t4_empty", fetch_valid_o, 1'b0);
        chk("t4_entries", 32'(got.size()), 32'd3);
        chkb("t4_got_fault", got[2].fault, 1'b1);
        branch_request_i = 1'b1; branch_pc_i = 32'h8000_0000;
        #1;
        tick();
        branch_request_i = 1'b0;
        #1;
        chkb("t4_rd_resume", icache_rd_o, 1'b1);
        chk("t4_pc_resume", icache_pc_o, 32'h8000_0000);
        tick();
        tick();
        chkb("t4_valid_resume", fetch_valid_o, 1'b1);
        chk("t4_out_pc_resume", fetch_pc_o, 32'h8000_0000);
        chkb("t4_fault_resume", fetch_fault_o, 1'b0);
        err_pc = 32'hFFFF_FFFF;

        // Redirect coinciding with a response, then PC wrap
        do_reset();
        rst_i = 1'b1; fetch_accept_i = 1'b1; icache_accept_i = 1'b1;
        #1;
        tick();
        icache_valid_i = 1'b1; icache_inst_i = INST_NOP;
        branch_request_i = 1'b1; branch_pc_i = 32'hFFFF_FFFF;
        #1;
        chkb("t5_rd_branch", icache_rd_o, 1'b0);
        tick();
        icache_valid_i = 1'b0; branch_request_i = 1'b0;
        #1;
        chkb("t5_not_pushed", fetch_valid_o, 1'b0);
        chkb("t5_rd", icache_rd_o, 1'b1);
        chk("t5_aligned_pc", icache_pc_o, 32'hFFFF_FFFC);
        auto_cache = 1'b1;
        tick();
        chk("t5_wrap_pc", icache_pc_o, 32'h0000_0000);
        repeat (3) tick();
        chkb("t5_count", got.size() >= 2, 1'b1);
        chk("t5_first", got[0].pc, 32'hFFFF_FFFC);
        chk("t5_wrapped", got[1].pc, 32'h0000_0000);

        // Reset in the middle of traffic, late response afterwards
        do_reset();
        rst_i = 1'b1; fetch_accept_i = 1'b0; icache_accept_i = 1'b1; auto_cache = 1'b1;
        #1;
        tick();
        tick();
        auto_cache = 1'b0; icache_valid_i = 1'b0;
        #1;
        chkb("t6_busy_valid", fetch_valid_o, 1'b1);
        chkb("t6_busy_rd", icache_rd_o, 1'b0);
        rst_i = 1'b0;
        tick();
        chkb("t6_rst_valid", fetch_valid_o, 1'b0);
        chkb("t6_rst_rd", icache_rd_o, 1'b0);
        chk("t6_rst_pc", icache_pc_o, 32'h8000_0000);
        chk("t6_rst_fetch_pc", fetch_pc_o, 32'h0);
        chk("t6_rst_instr", fetch_instr_o, 32'h0);
        rst_i = 1'b1; icache_accept_i = 1'b0; icache_valid_i = 1'b1; icache_inst_i = 32'hDEAD_BEEF;
        #1;
        chkb("t6_rd_first", icache_rd_o, 1'b1);
        tick();
        icache_valid_i = 1'b0;
        #1;
        chkb("t6_late_ignored", fetch_valid_o, 1'b0);
        chkb("t6_rd_again", icache_rd_o, 1'b1);
        chk("t6_pc_again", icache_pc_o, 32'h8000_0000);
        auto_cache = 1'b1; icache_accept_i = 1'b1;
        #1;
        tick();
        tick();
        chkb("t6_valid", fetch_valid_o, 1'b1);
        chk("t6_out_pc", fetch_pc_o, 32'h8000_0000);
        chk("t6_out_instr", fetch_instr_o, INST_NOP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
